// File: rtl/dbus_demux_1x2.sv
// ---------------------------------------------------------------------------
// dbus_demux_1x2
//
// Purpose:
//   Steers the load/store unit's data-bus stream to one of two targets:
//   A (data memory, req_addr[SEL_BIT]=0) or B (MMIO, req_addr[SEL_BIT]=1).
//   Each target gets a registered request slot. A tag FIFO records which
//   target owns each outstanding request, so responses go back to the
//   initiator strictly in request order.
//
// Parameters:
//   SEL_BIT  address bit that selects the target (0 -> A, 1 -> B); < 31
//   DEPTH    max outstanding requests; power of 2, >= 2
//
// Optional feature (compile-time macro DBUS_RANGE_ERR_EN):
//   defined   : requests with any of req_addr[31:SEL_BIT+1] set are not
//               forwarded. They get an in-order error response
//               (rsp_rdata=0, rsp_err=1).
//   undefined : only req_addr[SEL_BIT] routes, rsp_err is tied 0 and the
//               tag is 1 bit.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/ready/addr/wdata/we   initiator request
//   rsp_valid/ready/rdata/err       initiator response
//   {a,b}_req_valid/ready/addr/wdata/we   registered target request
//   {a,b}_rsp_valid/ready/rdata           target response
// ---------------------------------------------------------------------------
module dbus_demux_1x2 #(
  parameter int SEL_BIT = 16,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,

  output logic        a_req_valid,
  input  logic        a_req_ready,
  output logic [31:0] a_req_addr,
  output logic [31:0] a_req_wdata,
  output logic        a_req_we,
  input  logic        a_rsp_valid,
  output logic        a_rsp_ready,
  input  logic [31:0] a_rsp_rdata,

  output logic        b_req_valid,
  input  logic        b_req_ready,
  output logic [31:0] b_req_addr,
  output logic [31:0] b_req_wdata,
  output logic        b_req_we,
  input  logic        b_rsp_valid,
  output logic        b_rsp_ready,
  input  logic [31:0] b_rsp_rdata,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

`ifdef DBUS_RANGE_ERR_EN
  localparam int TW = 2;
`else
  localparam int TW = 1;
`endif

  localparam logic [TW-1:0] TAG_A   = TW'(0);
  localparam logic [TW-1:0] TAG_B   = TW'(1);
`ifdef DBUS_RANGE_ERR_EN
  localparam logic [TW-1:0] TAG_ERR = TW'(2);
`endif

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  // Request slots
  logic          r_a_valid;
  logic [31:0]   r_a_addr;
  logic [31:0]   r_a_wdata;
  logic          r_a_we;
  logic          r_b_valid;
  logic [31:0]   r_b_addr;
  logic [31:0]   r_b_wdata;
  logic          r_b_we;

  // Tag FIFO
  logic [TW-1:0] r_tag_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic [TW-1:0] w_tag_in;
  logic          w_slot_ok;
  logic          w_req_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_load_a;
  logic          w_load_b;
  logic [TW-1:0] w_head;

  logic          w_rsp_valid;
  logic [31:0]   w_rsp_rdata;
  logic          w_rsp_err;
  logic          w_a_rsp_ready;
  logic          w_b_rsp_ready;

  assign w_full  = (r_count == COUNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_head  = r_tag_mem[r_rptr];

  // Routing decision. Readiness looks only at the addressed slot, so a
  // stalled target never blocks traffic to the other one.
  always_comb begin
    w_tag_in  = TAG_A;
    w_slot_ok = !r_a_valid || a_req_ready;
    if (req_addr[SEL_BIT]) begin
      w_tag_in  = TAG_B;
      w_slot_ok = !r_b_valid || b_req_ready;
    end
`ifdef DBUS_RANGE_ERR_EN
    // Out-of-range requests never occupy a slot; only FIFO space matters.
    if (|req_addr[31:SEL_BIT+1]) begin
      w_tag_in  = TAG_ERR;
      w_slot_ok = 1'b1;
    end
`endif
  end

  assign w_req_ready = !w_full && w_slot_ok;
  assign w_push      = req_valid && w_req_ready;
  assign w_load_a    = w_push && (w_tag_in == TAG_A);
  assign w_load_b    = w_push && (w_tag_in == TAG_B);

  // Slot A: a same-cycle reload wins over the clear, giving full-rate
  // back-to-back requests to one target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
      r_a_we    <= 1'b0;
    end else if (w_load_a) begin
      r_a_valid <= 1'b1;
      r_a_addr  <= req_addr;
      r_a_wdata <= req_wdata;
      r_a_we    <= req_we;
    end else if (r_a_valid && a_req_ready) begin
      r_a_valid <= 1'b0;
    end
  end

  // Slot B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b_addr  <= '0;
      r_b_wdata <= '0;
      r_b_we    <= 1'b0;
    end else if (w_load_b) begin
      r_b_valid <= 1'b1;
      r_b_addr  <= req_addr;
      r_b_wdata <= req_wdata;
      r_b_we    <= req_we;
    end else if (r_b_valid && b_req_ready) begin
      r_b_valid <= 1'b0;
    end
  end

  // Response path, combinational from the FIFO head. The non-head target
  // is held off with ready=0. With the FIFO empty, nothing is accepted.
  always_comb begin
    w_rsp_valid   = 1'b0;
    w_rsp_rdata   = '0;
    w_rsp_err     = 1'b0;
    w_a_rsp_ready = 1'b0;
    w_b_rsp_ready = 1'b0;
    if (!w_empty) begin
`ifdef DBUS_RANGE_ERR_EN
      if (w_head == TAG_ERR) begin
        w_rsp_valid = 1'b1;
        w_rsp_err   = 1'b1;
      end else
`endif
      if (w_head == TAG_B) begin
        w_rsp_valid   = b_rsp_valid;
        w_rsp_rdata   = b_rsp_rdata;
        w_b_rsp_ready = rsp_ready;
      end else begin
        w_rsp_valid   = a_rsp_valid;
        w_rsp_rdata   = a_rsp_rdata;
        w_a_rsp_ready = rsp_ready;
      end
    end
  end

  assign w_pop = w_rsp_valid && rsp_ready;

  // Tag FIFO. Push is gated by !full through w_req_ready, so a full FIFO
  // refuses a push even when it pops in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag_mem[i] <= TAG_A;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tag_mem[r_wptr] <= w_tag_in;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign req_ready   = w_req_ready;

  assign a_req_valid = r_a_valid;
  assign a_req_addr  = r_a_addr;
  assign a_req_wdata = r_a_wdata;
  assign a_req_we    = r_a_we;
  assign a_rsp_ready = w_a_rsp_ready;

  assign b_req_valid = r_b_valid;
  assign b_req_addr  = r_b_addr;
  assign b_req_wdata = r_b_wdata;
  assign b_req_we    = r_b_we;
  assign b_rsp_ready = w_b_rsp_ready;

  assign rsp_valid   = w_rsp_valid;
  assign rsp_rdata   = w_rsp_rdata;
  assign rsp_err     = w_rsp_err;

endmodule

// File: tb/tb_dbus_demux_1x2.sv
module tb_dbus_demux_1x2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_total;
  int n_bad;

  dbus_demux_1x2 #(.SEL_BIT(16), .DEPTH(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_we      (req_we),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .a_req_we    (a_req_we),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_ready (a_rsp_ready),
    .a_rsp_rdata (a_rsp_rdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_addr  (b_req_addr),
    .b_req_wdata (b_req_wdata),
    .b_req_we    (b_req_we),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_ready (b_rsp_ready),
    .b_rsp_rdata (b_rsp_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_we    = we;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    idle_req();
    a_req_ready = 1'b1; b_req_ready = 1'b1;
    a_rsp_valid = 1'b0; b_rsp_valid = 1'b0;
    a_rsp_rdata = '0;   b_rsp_rdata = '0;
    rsp_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_a_valid", 32'(a_req_valid), 32'd0);
    chk("rst_b_valid", 32'(b_req_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_a_addr", a_req_addr, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: write to A, forwarded one cycle later, response passes through
    drive_req(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    #1 chk("t1_req_ready", 32'(req_ready), 32'd1);
    tick();
    idle_req();
    chk("t1_a_valid", 32'(a_req_valid), 32'd1);
    chk("t1_a_addr", a_req_addr, 32'h0000_0010);
    chk("t1_a_wdata", a_req_wdata, 32'hDEAD_BEEF);
    chk("t1_a_we", 32'(a_req_we), 32'd1);
    chk("t1_b_valid", 32'(b_req_valid), 32'd0);
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_1234; rsp_ready = 1'b1;
    #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_rdata", rsp_rdata, 32'h0000_1234);
    chk("t1_a_rsp_ready", 32'(a_rsp_ready), 32'd1);
    tick();
    a_rsp_valid = 1'b0;
    #1;
    chk("t1_a_cleared", 32'(a_req_valid), 32'd0);
    chk("t1_rsp_idle", 32'(rsp_valid), 32'd0);

    // 2: read A then B; B answers first and must wait
    rsp_ready = 1'b0;
    drive_req(32'h0000_0010, 32'h0, 1'b0);
    tick();
    drive_req(32'h0001_0010, 32'h0, 1'b0);
    tick();
    idle_req();
    chk("t2_b_valid", 32'(b_req_valid), 32'd1);
    b_rsp_valid = 1'b1; b_rsp_rdata = 32'h0000_BBBB; rsp_ready = 1'b1;
    #1;
    chk("t2_b_held", 32'(b_rsp_ready), 32'd0);
    chk("t2_rsp_wait", 32'(rsp_valid), 32'd0);
    tick();
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_AAAA;
    #1;
    chk("t2_first_rdata", rsp_rdata, 32'h0000_AAAA);
    chk("t2_first_a_ready", 32'(a_rsp_ready), 32'd1);
    chk("t2_first_b_ready", 32'(b_rsp_ready), 32'd0);
    tick();
    a_rsp_valid = 1'b0;
    #1;
    chk("t2_second_valid", 32'(rsp_valid), 32'd1);
    chk("t2_second_rdata", rsp_rdata, 32'h0000_BBBB);
    chk("t2_second_b_ready", 32'(b_rsp_ready), 32'd1);
    tick();
    b_rsp_valid = 1'b0;
    #1 chk("t2_drained", 32'(rsp_valid), 32'd0);

    // 3: fill the tag FIFO (A,B,A,B), 5th request stalls
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req((i % 2 == 1) ? 32'h0001_0100 : 32'h0000_0100, 32'(i), 1'b0);
      tick();
    end
    drive_req(32'h0000_0200, 32'h55, 1'b1);
    #1 chk("t3_full_ready", 32'(req_ready), 32'd0);
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_00A0; rsp_ready = 1'b1;
    #1;
    chk("t3_pop_valid", 32'(rsp_valid), 32'd1);
    chk("t3_full_pop_ready", 32'(req_ready), 32'd0);
    tick();
    a_rsp_valid = 1'b0; rsp_ready = 1'b0;
    #1 chk("t3_after_pop_ready", 32'(req_ready), 32'd1);
    tick();
    idle_req();
    // Queue now holds B,A,B,A
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_00A5;
    b_rsp_valid = 1'b1; b_rsp_rdata = 32'h0000_00B5;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_order", rsp_rdata, (i % 2 == 0) ? 32'h0000_00B5 : 32'h0000_00A5);
      tick();
    end
    #1;
    chk("t3_empty_valid", 32'(rsp_valid), 32'd0);
    chk("t3_empty_a_ready", 32'(a_rsp_ready), 32'd0);
    chk("t3_empty_b_ready", 32'(b_rsp_ready), 32'd0);
    a_rsp_valid = 1'b0; b_rsp_valid = 1'b0; rsp_ready = 1'b0;

    // 4: stalled A does not block B; then full-rate reload of A
    a_req_ready = 1'b0;
    drive_req(32'h0000_0020, 32'h20, 1'b1);
    tick();
    drive_req(32'h0000_0030, 32'h30, 1'b1);
    #1 chk("t4_a_stall", 32'(req_ready), 32'd0);
    drive_req(32'h0001_0040, 32'h40, 1'b0);
    #1 chk("t4_b_ready", 32'(req_ready), 32'd1);
    tick();
    idle_req();
    chk("t4_b_valid", 32'(b_req_valid), 32'd1);
    chk("t4_b_addr", b_req_addr, 32'h0001_0040);
    chk("t4_a_held", 32'(a_req_valid), 32'd1);
    chk("t4_a_addr", a_req_addr, 32'h0000_0020);
    a_req_ready = 1'b1;
    drive_req(32'h0000_0050, 32'h50, 1'b0);
    #1 chk("t4_reload_ready", 32'(req_ready), 32'd1);
    tick();
    idle_req();
    chk("t4_reload_valid", 32'(a_req_valid), 32'd1);
    chk("t4_reload_addr", a_req_addr, 32'h0000_0050);
    chk("t4_reload_we", 32'(a_req_we), 32'd0);
    tick();
    chk("t4_a_cleared", 32'(a_req_valid), 32'd0);
    // Drain A,B,A
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_0A00;
    b_rsp_valid = 1'b1; b_rsp_rdata = 32'h0000_0B00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_order", rsp_rdata, (i == 1) ? 32'h0000_0B00 : 32'h0000_0A00);
      tick();
    end
    a_rsp_valid = 1'b0; b_rsp_valid = 1'b0; rsp_ready = 1'b0;

    // 5: reset with 3 outstanding requests
    b_req_ready = 1'b0;
    drive_req(32'h0000_0060, 32'h60, 1'b0);
    tick();
    drive_req(32'h0001_0060, 32'h61, 1'b0);
    tick();
    drive_req(32'h0000_0064, 32'h62, 1'b0);
    tick();
    idle_req();
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_6666;
    #1;
    chk("t5_pre_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t5_pre_b_valid", 32'(b_req_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_a_valid", 32'(a_req_valid), 32'd0);
    chk("t5_rst_b_valid", 32'(b_req_valid), 32'd0);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_a_addr", a_req_addr, 32'h0);
    a_rsp_valid = 1'b0; b_req_ready = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    chk("t5_post_rsp_valid", 32'(rsp_valid), 32'd0);
    drive_req(32'h0000_0070, 32'h7070_7070, 1'b1);
    tick();
    idle_req();
    chk("t5_fresh_a_valid", 32'(a_req_valid), 32'd1);
    chk("t5_fresh_a_wdata", a_req_wdata, 32'h7070_7070);
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_0777; rsp_ready = 1'b1;
    #1 chk("t5_fresh_rdata", rsp_rdata, 32'h0000_0777);
    tick();
    a_rsp_valid = 1'b0; rsp_ready = 1'b0;
    #1 chk("t5_fresh_done", 32'(rsp_valid), 32'd0);

`ifdef DBUS_RANGE_ERR_EN
    // 6: out-of-range read between two A reads
    drive_req(32'h0000_0010, 32'h0, 1'b0);
    tick();
    drive_req(32'h8000_0000, 32'h0, 1'b0);
    tick();
    chk("t6_no_a_req", 32'(a_req_valid), 32'd0);
    chk("t6_no_b_req", 32'(b_req_valid), 32'd0);
    drive_req(32'h0000_0014, 32'h0, 1'b0);
    tick();
    idle_req();
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_0011; rsp_ready = 1'b1;
    #1;
    chk("t6_r1_rdata", rsp_rdata, 32'h0000_0011);
    chk("t6_r1_err", 32'(rsp_err), 32'd0);
    tick();
    a_rsp_valid = 1'b0;
    #1;
    chk("t6_r2_valid", 32'(rsp_valid), 32'd1);
    chk("t6_r2_rdata", rsp_rdata, 32'h0);
    chk("t6_r2_err", 32'(rsp_err), 32'd1);
    chk("t6_r2_a_ready", 32'(a_rsp_ready), 32'd0);
    tick();
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_0022;
    #1;
    chk("t6_r3_rdata", rsp_rdata, 32'h0000_0022);
    chk("t6_r3_err", 32'(rsp_err), 32'd0);
    tick();
    a_rsp_valid = 1'b0; rsp_ready = 1'b0;
`else
    // Upper address bits ignored: 0x8000_0010 routes to A
    drive_req(32'h8000_0010, 32'h0, 1'b0);
    tick();
    idle_req();
    chk("t6_upper_to_a", 32'(a_req_valid), 32'd1);
    a_rsp_valid = 1'b1; a_rsp_rdata = 32'h0000_0088; rsp_ready = 1'b1;
    #1 chk("t6_err_tied", 32'(rsp_err), 32'd0);
    tick();
    a_rsp_valid = 1'b0; rsp_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
